// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard detection with youngest-stage priority, a
// long-latency write scoreboard, a saturating stall counter and a stall watchdog.
module fwd_hazard_unit #(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int NSTG = 3,
  parameter int TMO  = 1024,
  parameter int CNTW = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic [NSRC*5-1:0]      src_addr_i,
  input  logic [NSTG*5-1:0]      stg_rd_i,
  input  logic [NSTG-1:0]        stg_wen_i,
  input  logic [NSTG-1:0]        stg_rdy_i,
  input  logic [NSTG*XLEN-1:0]   stg_dat_i,
  input  logic                   lng_issue_i,
  input  logic [4:0]             lng_issue_rd_i,
  input  logic                   lng_done_i,
  input  logic [4:0]             lng_done_rd_i,
  output logic [NSRC-1:0]        fwd_o,
  output logic [NSRC*XLEN-1:0]   fwd_dat_o,
  output logic                   stall_o,
  output logic [CNTW-1:0]        stall_cnt_o,
  output logic                   wdog_o
);

  localparam int RW = $clog2(TMO + 1);

  logic [31:0]      sb_q, sb_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]    run_q, run_d;
  logic             wdog_q, wdog_d;

  logic [NSRC-1:0]      fwd_v;
  logic [NSRC*XLEN-1:0] dat_v;
  logic [NSRC-1:0]      blk_v;
  logic [4:0]           a;
  logic                 hit;
  logic                 hit_rdy;
  logic [XLEN-1:0]      hit_dat;
  logic                 stall;

  // Stages are scanned oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_v   = '0;
    dat_v   = '0;
    blk_v   = '0;
    a       = '0;
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_dat = '0;
    for (int k = 0; k < NSRC; k++) begin
      a       = src_addr_i[5*k +: 5];
      hit     = 1'b0;
      hit_rdy = 1'b0;
      hit_dat = '0;
      for (int s = NSTG - 1; s >= 0; s--) begin
        if (stg_wen_i[s] && (stg_rd_i[5*s +: 5] == a)) begin
          hit     = 1'b1;
          hit_rdy = stg_rdy_i[s];
          hit_dat = stg_dat_i[XLEN*s +: XLEN];
        end
      end
      if (a != 5'd0) begin
        if (hit) begin
          if (hit_rdy) begin
            fwd_v[k]              = 1'b1;
            dat_v[XLEN*k +: XLEN] = hit_dat;
          end else begin
            blk_v[k] = 1'b1;
          end
        end else begin
          blk_v[k] = sb_q[a];
        end
      end
    end
    stall = |blk_v;
  end

  // Issue is applied after done so a same-cycle pair leaves the entry set.
  always_comb begin
    sb_d = sb_q;
    if (flush_i) begin
      sb_d = '0;
    end else begin
      if (lng_done_i)  sb_d[lng_done_rd_i]  = 1'b0;
      if (lng_issue_i) sb_d[lng_issue_rd_i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};

    run_d = '0;
    if (stall && !flush_i) begin
      run_d = (run_q == RW'(TMO)) ? run_q : run_q + RW'(1);
    end

    wdog_d = wdog_q | (stall && (run_q == RW'(TMO - 1)));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sb_q   <= '0;
      cnt_q  <= '0;
      run_q  <= '0;
      wdog_q <= 1'b0;
    end else begin
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      wdog_q <= wdog_d;
    end
  end

  assign fwd_o       = fwd_v;
  assign fwd_dat_o   = dat_v;
  assign stall_o     = stall;
  assign stall_cnt_o = cnt_q;
  assign wdog_o      = wdog_q;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and hazard unit for the Noname RISC-V pipeline. It serves NSRC register-source ports against NSTG in-flight producer stages, with youngest-stage priority. A registered per-register scoreboard tracks long-latency writes (loads, multi-cycle ops) that have left the forwarding stages. It also keeps a saturating stall-cycle counter and a stall watchdog.

## Interface
Parameters:
- XLEN, 32, datapath width
- NSRC, 2, number of source-operand ports
- NSTG, 3, number of producer stages; index 0 is youngest (EX), NSTG-1 oldest (WB)
- TMO, 1024, consecutive stall cycles before watchdog fires (≥2)
- CNTW, 32, stall counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rstn_i  in  1  reset; asynchronous and active-low
- flush_i  in  1  synchronous pipeline flush
- src_addr_i  in  NSRC*5  source register addresses, port k at [5k+4:5k]
- stg_rd_i  in  NSTG*5  destination register per stage
- stg_wen_i  in  NSTG  stage s will write stg_rd[s]
- stg_rdy_i  in  NSTG  stage s result is valid on stg_dat[s] this cycle
- stg_dat_i  in  NSTG*XLEN  stage results
- lng_issue_i  in  1  long-latency op to register lng_issue_rd_i leaves the tracked stages unfinished
- lng_issue_rd_i  in  5  its destination
- lng_done_i  in  1  long-latency result retired to the register file
- lng_done_rd_i  in  5  its destination
- fwd_o  out  NSRC  port k takes fwd_dat_o[k] instead of register-file data
- fwd_dat_o  out  NSRC*XLEN  forwarded operands
- stall_o  out  1  hold the issue stage this cycle
- stall_cnt_o  out  CNTW  total stall cycles, saturating
- wdog_o  out  1  sticky watchdog flag

## Operation
Forwarding is combinational, evaluated per port k with address a = src_addr[k]:
- If a == 0, there is no match and no stall: fwd_o[k]=0 and fwd_dat_o[k]=0.
- match[s] = stg_wen[s] && stg_rd[s]==a. Only the lowest s with match[s] is considered (youngest wins). Older matches are ignored even when ready.
- If the winning stage has stg_rdy=1: fwd_o[k]=1 and data = stg_dat[s].
- If the winning stage has stg_rdy=0: the port is blocked.
- If no stage matches and scoreboard[a]=1: the port is blocked.
- If no stage matches and scoreboard[a]=0: no forwarding.
- When fwd_o[k]=0, fwd_dat_o[k] reads 0.
- stall_o = OR of the blocked flags over all ports.

Scoreboard (31 flops; x0 is hard-wired 0):
- lng_issue_i sets the entry for lng_issue_rd_i. Issuing to an entry already set leaves it set.
- lng_done_i clears the entry for lng_done_rd_i. A done for an entry that is not set is ignored.
- Issue and done to the same register in the same cycle: the entry ends up set (issue wins).
- Issue or done addressed to x0 is ignored.
- flush_i clears all entries. Issue and done in the same cycle as flush are discarded.

Stall counter and watchdog:
- stall_cnt increments each cycle stall_o=1 and holds at 2^CNTW-1. It is not cleared by flush_i.
- run counter (width clog2(TMO+1)) increments while stall_o=1 and clears when stall_o=0 or flush_i=1.
- When run reaches TMO-1 while stall_o=1, wdog_o sets on that edge and stays set until reset.

## Timing
- Reset, asynchronous assert: scoreboard all 0, stall_cnt_o=0, run=0, wdog_o=0.
- Reset values of the combinational outputs depend only on the inputs (fwd_o and stall_o follow the inputs).
- Forwarding and stall have zero latency: inputs in cycle n drive the outputs in cycle n.
- Scoreboard updates have one-cycle latency:
  - Issue in cycle n blocks readers from cycle n+1.
  - Done in cycle n unblocks readers from cycle n+1.
  - A reader in cycle n with done in the same cycle still stalls (the register file writes at the edge).
- stall_cnt_o and wdog_o are registered and reflect stall_o of the previous cycle.
- wdog_o rises at the edge ending the TMO-th consecutive stall cycle.
- Reset asserted mid-stall clears all state immediately. stall_o recomputes from the inputs and the cleared scoreboard.

## Test plan
- NSTG=3: src0=5, stages 0 and 2 both write x5, both ready, dat 0xAAAA/0xCCCC -> fwd_o[0]=1, data 0xAAAA, stall_o=0.
- src1=7, stage 0 writes x7 with rdy=0, stage 1 writes x7 with rdy=1 -> stall_o=1, fwd_o[1]=0. Next cycle with stage0 rdy=1 -> stall_o=0, data = stg_dat[0].
- src0=0 with all stages writing x0 (rdy=0) -> fwd_o=0, stall_o=0.
- lng_issue x9 in cycle 1, src0=9 with no stage match:
  - Cycle 1: stall_o=0.
  - Cycles 2-4: stall_o=1.
  - lng_done x9 in cycle 4 -> stall_o=0 in cycle 5; stall_cnt_o=3 by cycle 5.
- Same-cycle issue and done on x12 -> scoreboard[12]=1 next cycle. flush_i the following cycle -> scoreboard[12]=0, stall drops.
- TMO=4, hold a stall -> wdog_o=0 after 3 cycles, 1 after 4, stays 1 after the stall ends. Assert rstn_i low -> wdog_o=0 and stall_cnt_o=0 asynchronously.
